// File: rtl/fifo_csr_master.sv
// Avalon-MM master that moves stream words into/out of the FIFO CSR slave, re-polling status before each access.
// Optional one-shot control-register write after reset when CTRL_INIT_EN is defined.
module fifo_csr_master #(
  parameter int               WIDTH         = 8,
  parameter int               POINTER_WIDTH = 4,
  parameter logic [WIDTH-1:0] CTRL_INIT     = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic                     src_valid,
  input  logic [WIDTH-1:0]         src_data,
  output logic                     src_ready,
  output logic                     snk_valid,
  output logic [WIDTH-1:0]         snk_data,
  input  logic                     snk_ready,
  output logic [1:0]               avm_address,
  output logic                     avm_read,
  output logic                     avm_write,
  output logic [WIDTH-1:0]         avm_writedata,
  input  logic [WIDTH-1:0]         avm_readdata,
  output logic                     st_full,
  output logic                     st_empty,
  output logic [POINTER_WIDTH:0]   st_count
);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
`ifdef CTRL_INIT_EN
    INIT      = 4'd1,
    INIT_GAP  = 4'd2,
`endif
    POLL      = 4'd3,
    POLL_WAIT = 4'd4,
    PUSH      = 4'd5,
    PUSH_GAP  = 4'd6,
    POP       = 4'd7,
    POP_WAIT  = 4'd8
  } state_t;

`ifdef CTRL_INIT_EN
  localparam state_t RESET_STATE = INIT;
`else
  localparam state_t RESET_STATE = IDLE;
`endif

  localparam logic [1:0] ADDR_STATUS = 2'b00;
  localparam logic [1:0] ADDR_READ   = 2'b01;
  localparam logic [1:0] ADDR_WRITE  = 2'b10;
  localparam logic [1:0] ADDR_CTRL   = 2'b11;

  state_t state, state_nxt;
  logic   last_grant_pop;
  logic   push_elig, pop_elig;

  // Eligibility is judged on the live status word returned for the poll.
  assign push_elig = src_valid && !avm_readdata[POINTER_WIDTH+2];
  assign pop_elig  = !avm_readdata[POINTER_WIDTH+1] && (!snk_valid || snk_ready);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= RESET_STATE;
      last_grant_pop <= 1'b1;
    end else begin
      state <= state_nxt;
      if (state_nxt == PUSH)
        last_grant_pop <= 1'b0;
      else if (state_nxt == POP)
        last_grant_pop <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (en) state_nxt = POLL;
`ifdef CTRL_INIT_EN
      INIT:      state_nxt = INIT_GAP;
      INIT_GAP:  state_nxt = IDLE;
`endif
      POLL:      state_nxt = POLL_WAIT;
      POLL_WAIT: begin
        if (push_elig && pop_elig)
          state_nxt = last_grant_pop ? PUSH : POP;
        else if (push_elig)
          state_nxt = PUSH;
        else if (pop_elig)
          state_nxt = POP;
        else
          state_nxt = IDLE;
      end
      PUSH:      state_nxt = PUSH_GAP;
      PUSH_GAP:  state_nxt = IDLE;
      POP:       state_nxt = POP_WAIT;
      POP_WAIT:  state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    avm_read    = 1'b0;
    avm_write   = 1'b0;
    avm_address = ADDR_STATUS;
    src_ready   = 1'b0;
    case (state)
      POLL: avm_read = 1'b1;
      PUSH: begin
        avm_write   = 1'b1;
        avm_address = ADDR_WRITE;
        src_ready   = 1'b1;
      end
      POP: begin
        avm_read    = 1'b1;
        avm_address = ADDR_READ;
      end
`ifdef CTRL_INIT_EN
      INIT: begin
        avm_write   = 1'b1;
        avm_address = ADDR_CTRL;
      end
`endif
      default: ;
    endcase
  end

`ifdef CTRL_INIT_EN
  assign avm_writedata = (state == INIT) ? CTRL_INIT : src_data;
`else
  // The control value plays no part when the init write is compiled out.
  logic unused_ctrl;
  assign unused_ctrl   = ^{CTRL_INIT, ADDR_CTRL};
  assign avm_writedata = src_data;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_count  <= '0;
      st_empty  <= 1'b0;
      st_full   <= 1'b0;
      snk_valid <= 1'b0;
      snk_data  <= '0;
    end else begin
      if (state == POLL_WAIT) begin
        st_count <= avm_readdata[POINTER_WIDTH:0];
        st_empty <= avm_readdata[POINTER_WIDTH+1];
        st_full  <= avm_readdata[POINTER_WIDTH+2];
      end
      if (state == POP_WAIT) begin
        snk_data  <= avm_readdata;
        snk_valid <= 1'b1;
      end else if (snk_valid && snk_ready) begin
        snk_valid <= 1'b0;
      end
    end
  end

endmodule
